// File: rtl/struct_field_serializer.sv
// Serializes one packed struct word (BYTE_FIELDS byte fields + one TAIL_W tail) into 16-bit beats, MS field first.
// Optional STRUCT_SER_CHECKSUM_EN appends an 8-bit modulo-256 checksum beat after the tail.
module struct_field_serializer #(
   parameter int WORD_W      = 215,
   parameter int BYTE_FIELDS = 25,
   parameter int TAIL_W      = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [15:0]       out_data,
   output logic [4:0]        out_idx,
   output logic              out_last,
   output logic              out_valid,
   input  logic              out_ready
);

   // state | meaning
   // IDLE  | waiting for a word, in_ready=1
   // EMIT  | presenting field idx from the top of sh
   // CSUM  | presenting the checksum beat (STRUCT_SER_CHECKSUM_EN only)
`ifdef STRUCT_SER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, EMIT, CSUM} state_t;
`else
   typedef enum logic [1:0] {IDLE, EMIT} state_t;
`endif

   localparam logic [4:0] TAIL_IDX = 5'(BYTE_FIELDS);

   state_t            state, state_nxt;
   logic [WORD_W-1:0] sh;
   logic [4:0]        idx;
`ifdef STRUCT_SER_CHECKSUM_EN
   logic [7:0]        sum;
`endif

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_idx   = '0;
      out_last  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = EMIT;
         end
         EMIT: begin
            out_valid = 1'b1;
            out_idx   = idx;
            if (idx == TAIL_IDX) begin
               out_data = 16'(sh[WORD_W-1 -: TAIL_W]);
`ifdef STRUCT_SER_CHECKSUM_EN
               if (out_ready) state_nxt = CSUM;
`else
               out_last = 1'b1;
               if (out_ready) state_nxt = IDLE;
`endif
            end else begin
               out_data = 16'(sh[WORD_W-1 -: 8]);
            end
         end
`ifdef STRUCT_SER_CHECKSUM_EN
         CSUM: begin
            out_valid = 1'b1;
            out_idx   = TAIL_IDX + 5'd1;
            out_data  = {8'b0, sum};
            out_last  = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sh    <= '0;
         idx   <= '0;
`ifdef STRUCT_SER_CHECKSUM_EN
         sum   <= '0;
`endif
      end else begin
         state <= state_nxt;
         if (state == IDLE && in_valid) begin
            sh  <= in_data;
            idx <= '0;
         end else if (state == EMIT && out_ready && idx != TAIL_IDX) begin
            sh  <= sh << 8;
            idx <= idx + 5'd1;
         end
`ifdef STRUCT_SER_CHECKSUM_EN
         // Byte fields have a zero upper half, so one expression covers every field including the tail.
         if (state == IDLE && in_valid)
            sum <= '0;
         else if (state == EMIT && out_ready)
            sum <= sum + out_data[7:0] + out_data[15:8];
`endif
      end
   end

endmodule

// File: tb/tb_struct_field_serializer.sv
// Scoreboard bench for struct_field_serializer: stimulus pushes expected beats, a monitor pops and compares.
module tb_struct_field_serializer;
   localparam int WORD_W = 215;
   localparam int NB     = 25;
   localparam int TW     = 15;

   typedef struct packed {
      logic [15:0] d;
      logic [4:0]  i;
      logic        l;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [WORD_W-1:0] in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [15:0]       out_data;
   logic [4:0]        out_idx;
   logic              out_last;
   logic              out_valid;
   logic              out_ready = 1'b1;

   struct_field_serializer #(.WORD_W(WORD_W), .BYTE_FIELDS(NB), .TAIL_W(TW)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   beat_t exp_q[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    cyc = 0;
   int    rdy_mode = 0;
   int    rdy_phase = 0;
   bit    seen_idx10 = 1'b0;
   bit    chk_b2b = 1'b0;
   int    last_cyc = -1;
   int    beats_accepted = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: fields taken arithmetically from the word, MS field first.
   task automatic push_word(input logic [WORD_W-1:0] w);
      beat_t b;
      logic [WORD_W-1:0] t;
      int s = 0;
      for (int k = 0; k < NB; k++) begin
         t = (w >> (WORD_W - 8 * (k + 1))) & WORD_W'(255);
         b.d = 16'(t);
         b.i = 5'(k);
         b.l = 1'b0;
         s += int'(b.d);
         exp_q.push_back(b);
      end
      t = w & WORD_W'((1 << TW) - 1);
      b.d = 16'(t);
      b.i = 5'(NB);
      s += int'(b.d) % 256 + int'(b.d) / 256;
`ifdef STRUCT_SER_CHECKSUM_EN
      b.l = 1'b0;
      exp_q.push_back(b);
      b.d = 16'(s % 256);
      b.i = 5'(NB + 1);
      b.l = 1'b1;
      exp_q.push_back(b);
`else
      b.l = 1'b1;
      exp_q.push_back(b);
`endif
   endtask

   function automatic logic [WORD_W-1:0] basic_word();
      logic [WORD_W-1:0] w = '0;
      logic [WORD_W-1:0] t;
      for (int k = 0; k < NB; k++) begin
         t = WORD_W'(NB - k);
         w |= t << (WORD_W - 8 * (k + 1));
      end
      return w;
   endfunction

   function automatic logic [WORD_W-1:0] rand_word();
      logic [WORD_W-1:0] w = '0;
      for (int k = 0; k < 7; k++) w = (w << 32) | WORD_W'($urandom);
      return w;
   endfunction

   // Drives a word, waits (bounded) for acceptance; hold keeps in_valid high afterwards.
   task automatic send_word(input logic [WORD_W-1:0] w, input bit hold);
      bit acc = 1'b0;
      in_data  = w;
      in_valid = 1'b1;
      push_word(w);
      for (int n = 0; n < 400 && !acc; n++) begin
         acc = in_ready;
         @(posedge clk); #1;
      end
      if (!acc) check("accept_timeout", 0, 1);
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      #1;
      case (rdy_mode)
         0: out_ready = 1'b1;
         1: begin
            out_ready = (rdy_phase == 0 || rdy_phase == 3);
            rdy_phase = (rdy_phase + 1) % 4;
         end
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: samples on the falling edge, away from the active edge.
   bit    prev_stall = 1'b0;
   beat_t prev_b;
   always @(negedge clk) begin
      beat_t got, e;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         check("in_ready_vs_out_valid", in_ready, !out_valid);
         got = '{d: out_data, i: out_idx, l: out_last};
         if (prev_stall) begin
            check("stall_valid_held", out_valid, 1);
            check("stall_beat_held", got, prev_b);
         end
         if (!out_valid) begin
            check("idle_out_data", out_data, 0);
         end
         if (out_valid && out_ready) begin
            beats_accepted++;
            if (exp_q.size() == 0) begin
               check("unexpected_beat", got, 0);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", got.d, e.d);
               check("beat_idx", got.i, e.i);
               check("beat_last", got.l, e.l);
               check("tail_bit15", out_data[15], 0);
            end
            if (out_idx == 5'd10) seen_idx10 = 1'b1;
            if (out_last && chk_b2b) last_cyc = cyc;
         end
         if (in_valid && in_ready && chk_b2b && last_cyc >= 0) begin
            check("b2b_accept_cycle", cyc, last_cyc + 1);
            last_cyc = -1;
         end
         prev_stall = out_valid && !out_ready;
         prev_b = got;
      end
   end

   task automatic check_reset_outputs();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_out_last", out_last, 0);
   endtask

   initial begin
      int n;
      logic [WORD_W-1:0] w;
      // Reset with in_valid asserted: reset wins.
      in_valid = 1'b1;
      in_data  = basic_word();
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst = 1'b0;
      check_reset_outputs();

      // Basic order.
      send_word(basic_word(), 1'b0);
      check("emit_in_ready_low", in_ready, 0);
      drain();

      // Tail width.
      w = WORD_W'(15'h7FFF);
      send_word(w, 1'b0);
      drain();

      // Backpressure 1,0,0,1.
      rdy_mode = 1;
      beats_accepted = 0;
      send_word(basic_word(), 1'b0);
      drain();
`ifdef STRUCT_SER_CHECKSUM_EN
      check("bp_beats", beats_accepted, NB + 2);
`else
      check("bp_beats", beats_accepted, NB + 1);
`endif
      rdy_mode = 0;

      // Reset mid-word after idx 10 is accepted.
      seen_idx10 = 1'b0;
      send_word(basic_word(), 1'b0);
      n = 0;
      while (!seen_idx10 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("saw_idx10", seen_idx10, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      check_reset_outputs();
      send_word(rand_word(), 1'b0);
      drain();

      // Back-to-back with in_valid held high.
      chk_b2b = 1'b1;
      send_word(rand_word(), 1'b1);
      send_word(rand_word(), 1'b1);
      send_word(rand_word(), 1'b0);
      drain();
      chk_b2b = 1'b0;

      // Random words under random backpressure.
      rdy_mode = 2;
      for (int k = 0; k < 12; k++) begin
         send_word(rand_word(), 1'($urandom_range(0, 1)));
      end
      in_valid = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/struct_field_serializer.md
Name: struct_field_serializer

Overview:
- Downstream consumer of the 215-bit packed struct word produced by the struct-assembly stage. That word holds 25 byte fields followed by one 15-bit tail field.
- The block accepts one packed word per transaction over a valid/ready handshake.
- It emits the fields one per beat, most-significant field first, on a 16-bit stream interface with field index and last marker.
- It sits between the struct builder and the byte-oriented transport/FIFO logic.

Parameters:
- WORD_W, 215, packed input word width; must equal BYTE_FIELDS*8 + TAIL_W.
- BYTE_FIELDS, 25, number of 8-bit fields at the top of the word.
- TAIL_W, 15, width of the final field in bits [TAIL_W-1:0]; must be <= 16.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WORD_W  packed struct word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word.
- out_data  output  16  current field, zero-extended.
- out_idx  output  5  field index; 0 = bits [214:207], 25 = tail.
- out_last  output  1  current beat is the final beat of the word.
- out_valid  output  1  out_data/out_idx/out_last are valid.
- out_ready  input  1  downstream accepts the beat.

Behaviour:
- Reset is synchronous and active-high: clk rising edge with rst=1 sets the following.
  - state=IDLE, in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0.
  - Shift register cleared.
- States: IDLE, EMIT (plus CSUM under the optional feature).
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, capture in_data into a WORD_W shift register, set idx=0, go to EMIT.
- EMIT:
  - in_ready=0, out_valid=1.
  - out_data = {8'b0, sh[WORD_W-1 -: 8]} while idx<BYTE_FIELDS.
  - When idx==BYTE_FIELDS: out_data = {{(16-TAIL_W){1'b0}}, sh[WORD_W-1 -: TAIL_W]}, out_last=1.
  - On out_valid&&out_ready with idx<BYTE_FIELDS: shift sh left by 8 and increment idx.
  - On the accepted tail beat: go to IDLE, or to CSUM when the feature is enabled.
- Latency: the first beat presents in the cycle after input acceptance. Throughput is one field per cycle with out_ready held high, i.e. 26 cycles per word plus one IDLE cycle.
- Backpressure: while out_valid && !out_ready, out_data, out_idx and out_last hold stable. No field is skipped or duplicated.
- in_ready is registered and only 1 in IDLE. No overlap between words; in_valid outside IDLE is ignored, and upstream must hold it.
- in_valid asserted on the same edge as rst: reset wins, word not captured.
- rst asserted mid-word: the word is dropped and outputs return to reset values on that edge; no partial last is emitted.
- out_last is asserted on exactly one beat per word: the tail, or the checksum beat under the feature.
- Tail upper bit out_data[15] is always 0 for TAIL_W=15.

Optional Feature:
- Macro: STRUCT_SER_CHECKSUM_EN.
- When defined:
  - An 8-bit running sum accumulates every accepted beat: byte fields in full, tail as tail[7:0] + tail[14:8], modulo 256.
  - The sum clears on word acceptance.
  - After the tail beat, state CSUM presents out_data={8'b0,sum}, out_idx=26, out_last=1. The tail beat then has out_last=0.
  - On acceptance of the CSUM beat, go to IDLE.
  - 27 beats per word.
- When undefined: no accumulator and no CSUM state; the tail beat carries out_last=1; 26 beats per word.

Test Plan:
- Basic order: word with byte field k = 25-k (k=0..24), tail=0, out_ready=1.
  - Beats 25,24,...,1, then 0 at idx 25 with out_last=1.
  - in_ready low from acceptance until the cycle after the last beat.
- Tail width: byte fields 0, tail=15'h7FFF.
  - Beat 25 out_data=16'h7FFF; all prior beats 0.
- Backpressure: same word as basic order, out_ready toggled 1,0,0,1 repeating.
  - Identical beat sequence.
  - Each beat held stable across stalled cycles; 26 accepted beats total.
- Reset mid-word: assert rst for one cycle after beat idx 10 is accepted.
  - Next cycle out_valid=0, in_ready=1.
  - A new word then starts cleanly at idx 0.
- Back-to-back words: in_valid held high with two words queued.
  - Second word accepted exactly one cycle after the first word's last beat is accepted; no beat loss.
- STRUCT_SER_CHECKSUM_EN defined, basic order word:
  - Tail beat out_last=0.
  - Beat idx 26 out_data=16'h0045 (sum 1..25 = 325 mod 256 = 69), out_last=1.
